audio_stream_buf: RTL and testbench
===================================

# audio_stream_buf

Sample buffering stage between the host/processing logic and the codec serial interface. A playback FIFO holds 32-bit stereo frames (left in [31:16], right in [15:0]) and presents the next frame to the codec's DAC parallel input. A capture FIFO stores each completed ADC frame. Both FIFOs advance only on the codec's once-per-frame `load_done_tick`, so the host side sees fully decoupled write/read handshakes.

## Interface
Parameters:
- `DEPTH_LOG2`, default 4: log2 of the depth of each FIFO. Depth is 16 frames at the default.

Ports:
- `clk`  in  1  system clock, the same clock as the codec interface.
- `reset`  in  1  synchronous, active-high reset.
- `play_wr`  in  1  host write strobe for the playback FIFO.
- `play_data`  in  32  frame to write.
- `play_full`  out  1  playback FIFO is full.
- `play_level`  out  DEPTH_LOG2+1  number of frames in the playback FIFO.
- `rec_rd`  in  1  host pop strobe for the capture FIFO.
- `rec_data`  out  32  head of the capture FIFO (first-word fall-through).
- `rec_empty`  out  1  capture FIFO is empty.
- `rec_level`  out  DEPTH_LOG2+1  number of frames in the capture FIFO.
- `load_done_tick`  in  1  one-cycle frame strobe from the codec interface.
- `adc_frame`  in  32  completed ADC frame from the codec interface.
- `dac_frame`  out  32  frame the codec loads on `load_done_tick`.
- `underrun`  out  1  sticky flag: a tick occurred with the playback FIFO empty.
- `overrun`  out  1  sticky flag: a tick occurred with the capture FIFO full.
- `clr_err`  in  1  clears both sticky flags (and counters, if present).
- `underrun_cnt`, `overrun_cnt`  out  8  error counters (see Configuration).

## Operation
- **Playback FIFO.** Circular RAM with DEPTH_LOG2-bit read/write pointers plus a separate occupancy counter.
  - `play_wr` while not full: write `play_data` and increment the level.
  - `play_wr` while full: the write is dropped silently and state is unchanged.
- **`dac_frame` register.** Holds the frame the codec captures on the current tick.
  - On `load_done_tick` with level > 0: load the FIFO head into `dac_frame` and pop it.
  - On `load_done_tick` with level = 0: load 32'h0 (mute) and set `underrun`.
- **Capture FIFO.** On `load_done_tick`, push `adc_frame`.
  - If the FIFO is full, drop the frame and set `overrun`. Existing contents are not overwritten.
  - `rec_rd` while not empty: pop. `rec_rd` while empty: ignored.
- **Simultaneous events.**
  - Host write and tick pop in the same cycle on the playback FIFO: both take effect and the level is unchanged. A write to a FIFO that was empty is not popped by a tick in the same cycle; that tick still mutes and sets `underrun`.
  - Host pop and tick push in the same cycle on the capture FIFO: both take effect. On a full FIFO the push still counts as an overrun, evaluated on the pre-cycle level.
- **Error flags.** `clr_err` has priority over a set in the same cycle.
- **Pointer wrap.** Pointers wrap modulo 2^DEPTH_LOG2. Level arithmetic is DEPTH_LOG2+1 bits wide and never exceeds 2^DEPTH_LOG2.

## Timing
- All outputs are registered, except `rec_data`, which is a combinational RAM read of the head pointer.
- Reset values:
  - Pointers and levels: 0.
  - `play_full` = 0, `rec_empty` = 1.
  - `dac_frame` = 0, `underrun` = 0, `overrun` = 0, counters = 0.
  - `rec_data` is undefined while `rec_empty` = 1.
- A written frame is visible in `play_level` on the next cycle. It reaches `dac_frame` on the first tick at which it is the head.
- Presentation latency: a frame moved into `dac_frame` on tick N is loaded by the codec on tick N+1. The register is therefore one frame of prefetch.
- A captured frame is visible on `rec_data` and `rec_empty` the cycle after the tick.
- A reset mid-stream discards all FIFO contents on the next edge. No partial frame is retained.

## Configuration
- `AUDIO_STREAM_BUF_ERR_CNT_EN`
  - **Defined:** `underrun_cnt` and `overrun_cnt` are 8-bit saturating counters (stop at 255). Each increments on the same events that set its sticky flag. Both clear on `reset` or `clr_err`.
  - **Undefined:** both counter ports are tied to 8'h0 and no counter logic is built. The sticky flags are always present.

## Test plan
- **Reset defaults:** reset, then idle 10 cycles -> `rec_empty`=1, `play_full`=0, both levels 0, `dac_frame`=0, flags 0.
- **Playback ordering:** write A1..A3, then 4 ticks 64 cycles apart -> `dac_frame` = A1, A2, A3, 0. `underrun` sets on the 4th tick only.
- **Playback full:** write 17 frames at DEPTH_LOG2=4 -> `play_full`=1 after the 16th. The 17th is dropped and `play_level`=16. Ticks drain 16 frames in order.
- **Capture overrun:** drive `adc_frame`=k on tick k for k=1..17 with no reads -> `overrun` sets at tick 17. Reading yields 1..16. With the macro defined, `overrun_cnt`=1.
- **Simultaneous events:** capture FIFO full with `rec_rd` and a tick in the same cycle -> the pop occurs, the push is dropped, `overrun`=1, level 15. Playback level 1 with `play_wr` and a tick in the same cycle -> level stays 1 and the head moves to `dac_frame`.
- **Error clear and mid-stream reset:** assert `clr_err` in the same cycle as an underrun tick -> the flag stays 0. Assert `reset` with both FIFOs half full -> levels are 0 on the next cycle.

Source files
------------

// File: rtl/audio_stream_buf_if.sv
// audio_stream_buf_if: bundles the host-side FIFO handshakes and the codec-side
// frame strobe/data of audio_stream_buf. The master modport is the host+codec
// side, the slave modport is the buffer itself. clk/reset are not part of it.
interface audio_stream_buf_if #(
  parameter int DEPTH_LOG2 = 4
);
  // host playback side
  logic                  play_wr;
  logic [31:0]           play_data;
  logic                  play_full;
  logic [DEPTH_LOG2:0]   play_level;
  // host capture side
  logic                  rec_rd;
  logic [31:0]           rec_data;
  logic                  rec_empty;
  logic [DEPTH_LOG2:0]   rec_level;
  // codec side
  logic                  load_done_tick;
  logic [31:0]           adc_frame;
  logic [31:0]           dac_frame;
  // error reporting
  logic                  underrun;
  logic                  overrun;
  logic                  clr_err;
  logic [7:0]            underrun_cnt;
  logic [7:0]            overrun_cnt;

  modport master (
    output play_wr, play_data, rec_rd, load_done_tick, adc_frame, clr_err,
    input  play_full, play_level, rec_data, rec_empty, rec_level,
           dac_frame, underrun, overrun, underrun_cnt, overrun_cnt
  );

  modport slave (
    input  play_wr, play_data, rec_rd, load_done_tick, adc_frame, clr_err,
    output play_full, play_level, rec_data, rec_empty, rec_level,
           dac_frame, underrun, overrun, underrun_cnt, overrun_cnt
  );
endinterface

// File: rtl/audio_stream_buf.sv
// audio_stream_buf: playback and capture frame FIFOs between host logic and the
// codec serial interface; both FIFOs advance on the codec's load_done_tick.
// Ports: clk, reset (sync, active-high), bus (audio_stream_buf_if.slave) carrying
// play_wr/play_data/play_full/play_level, rec_rd/rec_data/rec_empty/rec_level,
// load_done_tick/adc_frame/dac_frame, underrun/overrun/clr_err and the two
// error counters. Optional macro AUDIO_STREAM_BUF_ERR_CNT_EN builds 8-bit
// saturating error counters; without it the counter outputs are tied to zero.
// Latency: host write visible in play_level next cycle; captured frame visible
// on rec_data/rec_empty the cycle after the tick. Full/empty writes or reads
// are dropped silently; ticks never stall (mute on underrun, drop on overrun).
module audio_stream_buf #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic               clk,
  input  logic               reset,
  audio_stream_buf_if.slave  bus
);

  localparam int                  DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LVL_ZERO = '0;
  localparam logic [DEPTH_LOG2:0] LVL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

  // ---------------------------------------------------------------- playback
  logic [31:0]           r_play_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_play_wp;
  logic [DEPTH_LOG2-1:0] r_play_rp;
  logic [DEPTH_LOG2:0]   r_play_level;
  logic [DEPTH_LOG2:0]   w_play_level_nxt;
  logic                  r_play_full;
  logic [31:0]           r_dac_frame;
  logic                  w_play_push;
  logic                  w_play_pop;
  logic                  w_underrun_evt;

  // Both decisions use the pre-cycle level, so a frame written into an empty
  // FIFO cannot be popped by a tick in the same cycle.
  assign w_play_push    = bus.play_wr && (r_play_level != LVL_FULL);
  assign w_play_pop     = bus.load_done_tick && (r_play_level != LVL_ZERO);
  assign w_underrun_evt = bus.load_done_tick && (r_play_level == LVL_ZERO);

  always_comb begin
    w_play_level_nxt = r_play_level;
    if (w_play_push && !w_play_pop) begin
      w_play_level_nxt = r_play_level + 1'b1;
    end else if (w_play_pop && !w_play_push) begin
      w_play_level_nxt = r_play_level - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_play_push) begin
      r_play_mem[r_play_wp] <= bus.play_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_play_wp    <= '0;
      r_play_rp    <= '0;
      r_play_level <= '0;
      r_play_full  <= 1'b0;
      r_dac_frame  <= 32'h0;
    end else begin
      if (w_play_push) r_play_wp <= r_play_wp + 1'b1;
      if (w_play_pop)  r_play_rp <= r_play_rp + 1'b1;
      r_play_level <= w_play_level_nxt;
      r_play_full  <= (w_play_level_nxt == LVL_FULL);
      // One frame of prefetch: the codec loads this value on the next tick.
      if (bus.load_done_tick) begin
        r_dac_frame <= w_play_pop ? r_play_mem[r_play_rp] : 32'h0;
      end
    end
  end

  // ----------------------------------------------------------------- capture
  logic [31:0]           r_rec_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_rec_wp;
  logic [DEPTH_LOG2-1:0] r_rec_rp;
  logic [DEPTH_LOG2:0]   r_rec_level;
  logic [DEPTH_LOG2:0]   w_rec_level_nxt;
  logic                  r_rec_empty;
  logic                  w_rec_push;
  logic                  w_rec_pop;
  logic                  w_overrun_evt;

  // A full FIFO drops the tick's frame even if the host pops in the same cycle.
  assign w_rec_push    = bus.load_done_tick && (r_rec_level != LVL_FULL);
  assign w_rec_pop     = bus.rec_rd && (r_rec_level != LVL_ZERO);
  assign w_overrun_evt = bus.load_done_tick && (r_rec_level == LVL_FULL);

  always_comb begin
    w_rec_level_nxt = r_rec_level;
    if (w_rec_push && !w_rec_pop) begin
      w_rec_level_nxt = r_rec_level + 1'b1;
    end else if (w_rec_pop && !w_rec_push) begin
      w_rec_level_nxt = r_rec_level - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_rec_push) begin
      r_rec_mem[r_rec_wp] <= bus.adc_frame;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rec_wp    <= '0;
      r_rec_rp    <= '0;
      r_rec_level <= '0;
      r_rec_empty <= 1'b1;
    end else begin
      if (w_rec_push) r_rec_wp <= r_rec_wp + 1'b1;
      if (w_rec_pop)  r_rec_rp <= r_rec_rp + 1'b1;
      r_rec_level <= w_rec_level_nxt;
      r_rec_empty <= (w_rec_level_nxt == LVL_ZERO);
    end
  end

  // ------------------------------------------------------------ error flags
  logic r_underrun;
  logic r_overrun;

  // clr_err wins over a set event in the same cycle.
  always_ff @(posedge clk) begin
    if (reset || bus.clr_err) begin
      r_underrun <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      if (w_underrun_evt) r_underrun <= 1'b1;
      if (w_overrun_evt)  r_overrun  <= 1'b1;
    end
  end

`ifdef AUDIO_STREAM_BUF_ERR_CNT_EN
  logic [7:0] r_underrun_cnt;
  logic [7:0] r_overrun_cnt;

  always_ff @(posedge clk) begin
    if (reset || bus.clr_err) begin
      r_underrun_cnt <= 8'h0;
      r_overrun_cnt  <= 8'h0;
    end else begin
      if (w_underrun_evt && (r_underrun_cnt != 8'hFF)) r_underrun_cnt <= r_underrun_cnt + 8'h1;
      if (w_overrun_evt  && (r_overrun_cnt  != 8'hFF)) r_overrun_cnt  <= r_overrun_cnt + 8'h1;
    end
  end

  assign bus.underrun_cnt = r_underrun_cnt;
  assign bus.overrun_cnt  = r_overrun_cnt;
`else
  assign bus.underrun_cnt = 8'h0;
  assign bus.overrun_cnt  = 8'h0;
`endif

  // ----------------------------------------------------------------- outputs
  assign bus.play_full  = r_play_full;
  assign bus.play_level = r_play_level;
  assign bus.dac_frame  = r_dac_frame;
  assign bus.rec_level  = r_rec_level;
  assign bus.rec_empty  = r_rec_empty;
  // First-word fall-through: head is read combinationally from the RAM.
  assign bus.rec_data   = r_rec_mem[r_rec_rp];
  assign bus.underrun   = r_underrun;
  assign bus.overrun    = r_overrun;

endmodule

// File: tb/tb_audio_stream_buf.sv
// tb_audio_stream_buf: directed bench for audio_stream_buf with a queue-based
// reference model of both FIFOs, the dac_frame register and the error state.
// Ports: none; drives the DUT through an audio_stream_buf_if instance.
module tb_audio_stream_buf;

  localparam int DL2   = 4;
  localparam int DEPTH = 1 << DL2;
`ifdef AUDIO_STREAM_BUF_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk;
  logic reset;

  audio_stream_buf_if #(.DEPTH_LOG2(DL2)) bus ();

  audio_stream_buf #(.DEPTH_LOG2(DL2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model
  logic [31:0] q_play [$];
  logic [31:0] q_rec  [$];
  logic [31:0] exp_dac;
  bit          exp_under;
  bit          exp_over;
  int          exp_ucnt;
  int          exp_ocnt;

  int n_pass;
  int n_total;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic check_all();
    check("dac_frame",    bus.dac_frame, exp_dac);
    check("play_level",   32'(bus.play_level), 32'(q_play.size()));
    check("play_full",    32'(bus.play_full), 32'(q_play.size() == DEPTH));
    check("rec_level",    32'(bus.rec_level), 32'(q_rec.size()));
    check("rec_empty",    32'(bus.rec_empty), 32'(q_rec.size() == 0));
    check("underrun",     32'(bus.underrun), 32'(exp_under));
    check("overrun",      32'(bus.overrun), 32'(exp_over));
    check("underrun_cnt", 32'(bus.underrun_cnt), CNT_EN ? 32'(exp_ucnt) : 32'h0);
    check("overrun_cnt",  32'(bus.overrun_cnt), CNT_EN ? 32'(exp_ocnt) : 32'h0);
    if (q_rec.size() > 0) check("rec_data", bus.rec_data, q_rec[0]);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One clock of stimulus; the model is updated from the pre-cycle state.
  task automatic do_cycle(input bit wr, input logic [31:0] wd, input bit tk,
                          input logic [31:0] adc, input bit rd, input bit clr);
    int  pl;
    int  rl;
    bit  u_evt;
    bit  o_evt;
    pl    = q_play.size();
    rl    = q_rec.size();
    u_evt = 1'b0;
    o_evt = 1'b0;
    bus.play_wr        = wr;
    bus.play_data      = wd;
    bus.load_done_tick = tk;
    bus.adc_frame      = adc;
    bus.rec_rd         = rd;
    bus.clr_err        = clr;
    step();
    bus.play_wr        = 1'b0;
    bus.load_done_tick = 1'b0;
    bus.rec_rd         = 1'b0;
    bus.clr_err        = 1'b0;
    if (tk) begin
      if (pl > 0) exp_dac = q_play.pop_front();
      else begin
        exp_dac = 32'h0;
        u_evt   = 1'b1;
      end
    end
    if (wr && pl < DEPTH) q_play.push_back(wd);
    if (rd && rl > 0) void'(q_rec.pop_front());
    if (tk) begin
      if (rl < DEPTH) q_rec.push_back(adc);
      else o_evt = 1'b1;
    end
    if (clr) begin
      exp_under = 1'b0; exp_over = 1'b0; exp_ucnt = 0; exp_ocnt = 0;
    end else begin
      if (u_evt) begin exp_under = 1'b1; if (exp_ucnt < 255) exp_ucnt++; end
      if (o_evt) begin exp_over  = 1'b1; if (exp_ocnt < 255) exp_ocnt++; end
    end
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic wr_frame(input logic [31:0] d);
    do_cycle(1'b1, d, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic tick(input logic [31:0] adc);
    do_cycle(1'b0, 32'h0, 1'b1, adc, 1'b0, 1'b0);
  endtask

  task automatic rd_frame();
    do_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic clear_err();
    do_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    q_play.delete();
    q_rec.delete();
    exp_dac = 32'h0; exp_under = 1'b0; exp_over = 1'b0; exp_ucnt = 0; exp_ocnt = 0;
    check_all();
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    bus.play_wr = 1'b0; bus.play_data = 32'h0; bus.rec_rd = 1'b0;
    bus.load_done_tick = 1'b0; bus.adc_frame = 32'h0; bus.clr_err = 1'b0;
    reset = 1'b1;
    step();
    step();

    // reset defaults
    apply_reset();
    idle(10);

    // playback ordering and underrun on the 4th tick only
    wr_frame(32'hA1A1_0001);
    wr_frame(32'hA2A2_0002);
    wr_frame(32'hA3A3_0003);
    for (int t = 0; t < 4; t++) begin
      tick(32'hC0DE_0000 + 32'(t));
      if (t < 3) idle(63);
    end
    clear_err();
    while (q_rec.size() > 0) rd_frame();

    // playback full: 17th write dropped, drain in order
    for (int i = 0; i < DEPTH + 1; i++) wr_frame(32'hB000_0000 + 32'(i));
    for (int i = 0; i < DEPTH; i++) tick(32'hD000_0000 + 32'(i));
    while (q_rec.size() > 0) rd_frame();
    clear_err();

    // read on empty capture FIFO is ignored
    rd_frame();

    // capture overrun on tick 17, contents 1..16 intact
    for (int k = 1; k <= DEPTH + 1; k++) tick(32'(k));

    // simultaneous: full capture with pop + tick; playback level 1 with write + tick
    wr_frame(32'hE000_0001);
    do_cycle(1'b1, 32'hE000_0002, 1'b1, 32'h99, 1'b1, 1'b0);

    // clr_err beats an underrun tick in the same cycle
    tick(32'h55);
    clear_err();
    do_cycle(1'b0, 32'h0, 1'b1, 32'h66, 1'b0, 1'b1);
    tick(32'h77);

    // mid-stream reset with both FIFOs half full
    while (q_rec.size() > DEPTH / 2) rd_frame();
    for (int i = 0; i < DEPTH / 2; i++) wr_frame(32'hF000_0000 + 32'(i));
    apply_reset();

    // write into empty FIFO with a same-cycle tick: muted, then presented next tick
    do_cycle(1'b1, 32'h1234_5678, 1'b1, 32'h88, 1'b0, 1'b0);
    tick(32'h89);
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
